// File: rtl/line_window_buffer_if.sv
// Pixel-stream and window-output bundle for line_window_buffer.
// master drives the pixel stream; slave is the window generator.
interface line_window_buffer_if #(
   parameter int WIDTH        = 8,
   parameter int NUM_LINES    = 3,
   parameter int WINDOW_WIDTH = 3,
   parameter int COL_BITS     = 9,
   parameter int ROW_BITS     = 9
);
   logic                                    en;
   logic                                    in_valid;
   logic                                    in_sof;
   logic [WIDTH-1:0]                        in_data;
   logic [COL_BITS-1:0]                     line_len;
   logic [WIDTH*NUM_LINES*WINDOW_WIDTH-1:0] window;
   logic                                    out_valid;
   logic [COL_BITS-1:0]                     out_col;
   logic [ROW_BITS-1:0]                     out_row;

   modport master (
      output en, in_valid, in_sof, in_data, line_len,
      input  window, out_valid, out_col, out_row
   );

   modport slave (
      input  en, in_valid, in_sof, in_data, line_len,
      output window, out_valid, out_col, out_row
   );
endinterface

// File: rtl/line_window_buffer.sv
// Streaming WINDOW_WIDTH x NUM_LINES window generator over a raster pixel stream,
// with frame start, runtime line length and a window-valid flag with coordinates.
module line_window_buffer #(
   parameter int WIDTH           = 8,
   parameter int MAX_LINE_LENGTH = 320,
   parameter int NUM_LINES       = 3,
   parameter int WINDOW_WIDTH    = 3,
   parameter int COL_BITS        = 9,
   parameter int ROW_BITS        = 9
) (
   input logic               clk,
   input logic               rst,
   line_window_buffer_if.slave bus
);
   localparam int AW = (MAX_LINE_LENGTH > 1) ? $clog2(MAX_LINE_LENGTH) : 1;
   localparam int CW = WIDTH * NUM_LINES;
   localparam int T  = WIDTH * WINDOW_WIDTH;
   localparam int W  = T * NUM_LINES;
   localparam logic [COL_BITS-1:0] MAX_LEN = COL_BITS'(MAX_LINE_LENGTH);
   localparam logic [ROW_BITS-1:0] ROW_MAX = '1;

   typedef enum logic {S_IDLE, S_RUN} state_t;
   state_t r_state, w_state_nxt;

   logic                w_accept;
   logic                w_wrap;
   logic [COL_BITS-1:0] r_col, r_len, w_pcol, w_len_nxt;
   logic [ROW_BITS-1:0] r_row, w_prow;
   logic [AW-1:0]       w_addr;
   logic [WIDTH-1:0]    r_mem [NUM_LINES-1][MAX_LINE_LENGTH];
   logic [CW-1:0]       w_colvec;
   logic [CW-1:0]       r_cols [WINDOW_WIDTH];
   logic [W-1:0]        w_window;
   logic                r_out_valid;
   logic [COL_BITS-1:0] r_out_col;
   logic [ROW_BITS-1:0] r_out_row;

   assign w_accept = bus.en & bus.in_valid & ((r_state == S_RUN) | bus.in_sof);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_accept && bus.in_sof) w_state_nxt = S_RUN;
   end

   // r_col/r_row hold the coordinate of the next pixel; a sof overrides it with (0,0).
   always_comb begin
      w_pcol    = r_col;
      w_prow    = r_row;
      w_len_nxt = r_len;
      if (bus.in_sof) begin
         w_pcol = '0;
         w_prow = '0;
         if (32'(bus.line_len) >= WINDOW_WIDTH && 32'(bus.line_len) <= MAX_LINE_LENGTH)
            w_len_nxt = bus.line_len;
         else
            w_len_nxt = MAX_LEN;
      end
   end

   assign w_wrap = (w_pcol == (w_len_nxt - COL_BITS'(1)));
   assign w_addr = w_pcol[AW-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_col       <= '0;
         r_row       <= '0;
         r_len       <= MAX_LEN;
         r_out_valid <= 1'b0;
         r_out_col   <= '0;
         r_out_row   <= '0;
      end else begin
         r_out_valid <= w_accept && (32'(w_prow) >= NUM_LINES - 1) && (32'(w_pcol) >= WINDOW_WIDTH - 1);
         if (w_accept) begin
            r_len     <= w_len_nxt;
            r_out_col <= w_pcol;
            r_out_row <= w_prow;
            if (w_wrap) begin
               r_col <= '0;
               r_row <= (w_prow == ROW_MAX) ? w_prow : w_prow + ROW_BITS'(1);
            end else begin
               r_col <= w_pcol + COL_BITS'(1);
               r_row <= w_prow;
            end
         end
      end
   end

   // Line memories form a vertical shift chain per column; stale contents are masked by out_valid.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_mem[0][w_addr] <= bus.in_data;
         for (int unsigned k = 1; k < NUM_LINES - 1; k++)
            r_mem[k][w_addr] <= r_mem[k-1][w_addr];
      end
   end

   always_comb begin
      w_colvec = '0;
      w_colvec[CW-1 -: WIDTH] = bus.in_data;
      for (int unsigned k = 0; k < NUM_LINES - 1; k++)
         w_colvec[CW-1-(k+1)*WIDTH -: WIDTH] = r_mem[k][w_addr];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < WINDOW_WIDTH; i++)
            r_cols[i] <= '0;
      end else if (w_accept) begin
         r_cols[0] <= w_colvec;
         for (int unsigned i = 1; i < WINDOW_WIDTH; i++)
            r_cols[i] <= r_cols[i-1];
      end
   end

   always_comb begin
      w_window = '0;
      for (int unsigned r = 0; r < NUM_LINES; r++)
         for (int unsigned c = 0; c < WINDOW_WIDTH; c++)
            w_window[W-1-r*T-c*WIDTH -: WIDTH] = r_cols[c][CW-1-r*WIDTH -: WIDTH];
   end

   assign bus.window    = w_window;
   assign bus.out_valid = r_out_valid;
   assign bus.out_col   = r_out_col;
   assign bus.out_row   = r_out_row;
endmodule

// File: tb/tb_line_window_buffer.sv
// Scoreboard bench for line_window_buffer: a raster frame store predicts each valid
// window; two instances differ only in ROW_BITS to exercise row saturation.
module tb_line_window_buffer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   line_window_buffer_if #(.WIDTH(8), .NUM_LINES(3), .WINDOW_WIDTH(3), .COL_BITS(5), .ROW_BITS(4)) bus_a ();
   line_window_buffer_if #(.WIDTH(8), .NUM_LINES(3), .WINDOW_WIDTH(3), .COL_BITS(5), .ROW_BITS(2)) bus_b ();

   line_window_buffer #(
      .WIDTH(8), .MAX_LINE_LENGTH(16), .NUM_LINES(3), .WINDOW_WIDTH(3), .COL_BITS(5), .ROW_BITS(4)
   ) u_dut_a (
      .clk(clk), .rst(rst), .bus(bus_a.slave)
   );

   line_window_buffer #(
      .WIDTH(8), .MAX_LINE_LENGTH(16), .NUM_LINES(3), .WINDOW_WIDTH(3), .COL_BITS(5), .ROW_BITS(2)
   ) u_dut_b (
      .clk(clk), .rst(rst), .bus(bus_b.slave)
   );

   typedef struct {
      logic [71:0] win;
      int          col;
      int          row;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          pulses = 0;
   logic [7:0]  frame [0:7][0:15];
   bit          m_run = 0;
   int          m_col = 0, m_row = 0, m_len = 16;
   int          m_ocol = 0, m_orow = 0;
   bit          m_hold = 0;
   logic [71:0] m_hold_win = '0;

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [71:0] build_win(input int pr, input int pc);
      logic [71:0] w = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            w[71 - r*24 - c*8 -: 8] = frame[pr-r][pc-c];
      return w;
   endfunction

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_reset();
      m_run = 0; m_col = 0; m_row = 0; m_len = 16;
      m_ocol = 0; m_orow = 0; m_hold = 0;
      sb.delete();
   endtask

   task automatic check_zero(input string phase);
      check_val({phase, "_window_a"}, bus_a.window, 0);
      check_val({phase, "_valid_a"},  bus_a.out_valid, 0);
      check_val({phase, "_col_a"},    bus_a.out_col, 0);
      check_val({phase, "_row_a"},    bus_a.out_row, 0);
      check_val({phase, "_window_b"}, bus_b.window, 0);
      check_val({phase, "_valid_b"},  bus_b.out_valid, 0);
   endtask

   task automatic drive(input bit e, input bit v, input bit s, input logic [7:0] d, input int len);
      bit   acc;
      bit   ov = 0;
      int   pc, pr;
      exp_t x;
      bus_a.en = e; bus_a.in_valid = v; bus_a.in_sof = s; bus_a.in_data = d; bus_a.line_len = 5'(len);
      bus_b.en = e; bus_b.in_valid = v; bus_b.in_sof = s; bus_b.in_data = d; bus_b.line_len = 5'(len);
      acc = e && v && (m_run || s);
      if (acc) begin
         if (s) begin
            pc = 0; pr = 0; m_run = 1;
            m_len = (len >= 3 && len <= 16) ? len : 16;
         end else begin
            pc = m_col; pr = m_row;
         end
         frame[pr][pc] = d;
         ov = (pr >= 2) && (pc >= 2);
         m_ocol = pc; m_orow = pr;
         if (pc == m_len - 1) begin m_col = 0; m_row = pr + 1; end
         else                 begin m_col = pc + 1; m_row = pr; end
         if (ov) begin
            x.win = build_win(pr, pc); x.col = pc; x.row = pr;
            sb.push_back(x);
            m_hold_win = x.win;
         end
         m_hold = ov;
      end
      @(posedge clk); #1;
      check_val("out_valid_a", bus_a.out_valid, ov);
      check_val("out_valid_b", bus_b.out_valid, ov);
      check_val("out_col_a", bus_a.out_col, m_ocol);
      check_val("out_col_b", bus_b.out_col, m_ocol);
      check_val("out_row_a", bus_a.out_row, sat(m_orow, 15));
      check_val("out_row_b", bus_b.out_row, sat(m_orow, 3));
      if (bus_a.out_valid) begin
         pulses++;
         if (sb.size() == 0) begin
            check_val("unexpected_valid", bus_a.out_valid, 0);
         end else begin
            x = sb.pop_front();
            check_val("window_a", bus_a.window, x.win);
            check_val("window_b", bus_b.window, x.win);
            check_val("sb_col", bus_a.out_col, x.col);
         end
      end else if (m_hold) begin
         check_val("hold_window_a", bus_a.window, m_hold_win);
         check_val("hold_window_b", bus_b.window, m_hold_win);
      end
   endtask

   task automatic run_frame(input int rows, input int len, input bit gaps, input int max_px);
      int eff = (len >= 3 && len <= 16) ? len : 16;
      int n = 0;
      for (int r = 0; r < rows; r++) begin
         for (int c = 0; c < eff; c++) begin
            if (n >= max_px) return;
            if (gaps) begin
               repeat ($urandom_range(0, 2)) begin
                  case ($urandom_range(0, 2))
                     0:       drive(1'b0, 1'b1, 1'b0, 8'hEE, 5);
                     1:       drive(1'b1, 1'b0, 1'b0, 8'hDD, 12);
                     default: drive(1'b0, 1'b1, 1'b1, 8'hCC, 4);
                  endcase
               end
            end
            drive(1'b1, 1'b1, (r == 0 && c == 0), 8'(r*16 + c), len);
            n++;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus_a.en = 0; bus_a.in_valid = 0; bus_a.in_sof = 0; bus_a.in_data = '0; bus_a.line_len = '0;
      bus_b.en = 0; bus_b.in_valid = 0; bus_b.in_sof = 0; bus_b.in_data = '0; bus_b.line_len = '0;
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      rst = 1'b0;

      // pixels before any sof are ignored
      repeat (4) drive(1'b1, 1'b1, 1'b0, 8'h55, 8);

      // line_len below WINDOW_WIDTH clamps to 16
      pulses = 0;
      run_frame(3, 2, 1'b0, 999);
      check_val("clamp_pulses", pulses, 14);

      pulses = 0;
      run_frame(4, 8, 1'b0, 999);
      check_val("full_pulses", pulses, 12);

      pulses = 0;
      run_frame(4, 8, 1'b1, 999);
      check_val("gap_pulses", pulses, 12);

      // sof lands on (3,5) of a running frame
      run_frame(4, 8, 1'b0, 3*8 + 5);
      pulses = 0;
      run_frame(4, 8, 1'b0, 999);
      check_val("restart_pulses", pulses, 12);

      // async reset mid row 2
      run_frame(4, 8, 1'b0, 2*8 + 5);
      rst = 1'b1;
      #1;
      check_zero("midreset");
      model_reset();
      #1 rst = 1'b0;
      repeat (5) drive(1'b1, 1'b1, 1'b0, 8'h77, 8);
      pulses = 0;
      run_frame(4, 8, 1'b0, 999);
      check_val("post_reset_pulses", pulses, 12);

      // six rows: instance b saturates out_row at 3
      pulses = 0;
      run_frame(6, 8, 1'b0, 999);
      check_val("six_row_pulses", pulses, 24);

      drive(1'b0, 1'b0, 1'b0, 8'h00, 8);
      check_val("sb_drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
